// File: rtl/fram_pkg.sv
// Shared definitions for the two-port FRAM arbiter: widths, port count,
// arbiter FSM encoding and the round-robin pick helper.
package fram_pkg;

  localparam int NUM_PORTS = 2;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Lone pending port wins; on contention the port holding priority wins.
  function automatic logic rr_pick(input logic [NUM_PORTS-1:0] pend, input logic prio);
    logic win;
    if (pend[0] && pend[1]) begin
      win = prio;
    end else begin
      win = pend[1];
    end
    return win;
  endfunction

endpackage

// File: rtl/fram_arbiter_if.sv
// Requester and FRAM-controller signal bundle of the arbiter.
// Handshake: a one-cycle we/re strobe is a request; done is a one-cycle
// completion pulse; busy marks a pending or active transaction.
interface fram_arbiter_if;
  import fram_pkg::*;

  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_we;
  logic              m0_re;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_done;
  logic              m0_busy;
  logic              m0_err;

  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_we;
  logic              m1_re;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_done;
  logic              m1_busy;
  logic              m1_err;

  logic [ADDR_W-1:0] fram_address;
  logic [DATA_W-1:0] fram_write_data;
  logic              fram_we;
  logic              fram_re;
  logic [DATA_W-1:0] fram_read_data;
  logic              fram_done;

  modport slave (
    input  m0_addr, m0_wdata, m0_we, m0_re,
    output m0_rdata, m0_done, m0_busy, m0_err,
    input  m1_addr, m1_wdata, m1_we, m1_re,
    output m1_rdata, m1_done, m1_busy, m1_err,
    output fram_address, fram_write_data, fram_we, fram_re,
    input  fram_read_data, fram_done
  );

  modport master (
    output m0_addr, m0_wdata, m0_we, m0_re,
    input  m0_rdata, m0_done, m0_busy, m0_err,
    output m1_addr, m1_wdata, m1_we, m1_re,
    input  m1_rdata, m1_done, m1_busy, m1_err,
    input  fram_address, fram_write_data, fram_we, fram_re,
    output fram_read_data, fram_done
  );

endinterface

// File: rtl/fram_port_latch.sv
// Per-port holding register: captures one request, reports busy, and
// flags strobes that arrive while a transaction is still outstanding.
module fram_port_latch
  import fram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              re,
  input  logic              retire,
  output logic              pending,
  output logic              busy,
  output logic              is_write,
  output logic              err,
  output logic [ADDR_W-1:0] hold_addr,
  output logic [DATA_W-1:0] hold_wdata
);

  logic strobe;
  logic accept;

  assign strobe = we | re;
  // The retiring cycle already counts as free so back-to-back requests chain.
  assign busy   = pending & ~retire;
  assign accept = strobe & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      is_write   <= 1'b0;
      err        <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else begin
      err <= strobe & busy;
      if (accept) begin
        pending    <= 1'b1;
        is_write   <= we;
        hold_addr  <= addr;
        hold_wdata <= wdata;
      end else if (retire) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fram_arbiter.sv
// Two-requester round-robin arbiter in front of a single FRAM SPI
// controller; one transaction in flight at a time.
module fram_arbiter
  import fram_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fram_arbiter_if.slave bus,
  output arb_state_t    dbg_state
);

  arb_state_t state, state_n;
  logic       grant, grant_n;
  logic       prio, prio_n;
  logic       pick;

  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] busy;
  logic [NUM_PORTS-1:0] is_write;
  logic [NUM_PORTS-1:0] err;
  logic [NUM_PORTS-1:0] retire;
  logic [NUM_PORTS-1:0] in_we;
  logic [NUM_PORTS-1:0] in_re;
  logic [ADDR_W-1:0]    in_addr    [NUM_PORTS];
  logic [DATA_W-1:0]    in_wdata   [NUM_PORTS];
  logic [ADDR_W-1:0]    hold_addr  [NUM_PORTS];
  logic [DATA_W-1:0]    hold_wdata [NUM_PORTS];
  logic [DATA_W-1:0]    rdata_q    [NUM_PORTS];

  assign in_addr[0]  = bus.m0_addr;
  assign in_addr[1]  = bus.m1_addr;
  assign in_wdata[0] = bus.m0_wdata;
  assign in_wdata[1] = bus.m1_wdata;
  assign in_we       = {bus.m1_we, bus.m0_we};
  assign in_re       = {bus.m1_re, bus.m0_re};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign retire[p] = (state == RESP) && (grant == 1'(p));

    fram_port_latch u_latch (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr       (in_addr[p]),
      .wdata      (in_wdata[p]),
      .we         (in_we[p]),
      .re         (in_re[p]),
      .retire     (retire[p]),
      .pending    (pending[p]),
      .busy       (busy[p]),
      .is_write   (is_write[p]),
      .err        (err[p]),
      .hold_addr  (hold_addr[p]),
      .hold_wdata (hold_wdata[p])
    );
  end

  assign pick = rr_pick(pending, prio);

  always_comb begin
    state_n = state;
    grant_n = grant;
    prio_n  = prio;
    case (state)
      IDLE: begin
        if (|pending) begin
          grant_n = pick;
          prio_n  = ~pick;
          state_n = ISSUE;
        end
      end
      ISSUE:   state_n = WAIT;
      WAIT:    if (bus.fram_done) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      prio       <= 1'b0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      prio  <= prio_n;
      // Write completions leave the port's last read result untouched.
      if ((state == WAIT) && bus.fram_done && !is_write[grant]) begin
        rdata_q[grant] <= bus.fram_read_data;
      end
    end
  end

  // Address and data stay on the bus from ISSUE until fram_done is taken.
  assign bus.fram_address    = ((state == ISSUE) || (state == WAIT)) ? hold_addr[grant]  : '0;
  assign bus.fram_write_data = ((state == ISSUE) || (state == WAIT)) ? hold_wdata[grant] : '0;
  assign bus.fram_we         = (state == ISSUE) &&  is_write[grant];
  assign bus.fram_re         = (state == ISSUE) && !is_write[grant];

  assign bus.m0_rdata = rdata_q[0];
  assign bus.m1_rdata = rdata_q[1];
  assign bus.m0_done  = retire[0];
  assign bus.m1_done  = retire[1];
  assign bus.m0_busy  = busy[0];
  assign bus.m1_busy  = busy[1];
  assign bus.m0_err   = err[0];
  assign bus.m1_err   = err[1];

  assign dbg_state = state;

endmodule

// File: tb/tb_fram_arbiter.sv
// Bench for fram_arbiter: directed scenarios plus random traffic, checked by
// a scoreboard against a memory-level model and a behavioural FRAM controller.
module tb_fram_arbiter;
  import fram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  arb_state_t dbg_state;

  fram_arbiter_if bus();

  fram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FRAM contents as seen by the reference model and by the controller model.
  logic [31:0] ref_mem  [65536];
  logic [31:0] ctrl_mem [65536];

  logic [32:0] exp_q [2][$];   // {is_read, expected rdata}
  logic [48:0] req_q [2][$];   // {we, addr, wdata} expected on the FRAM side
  int          fram_order[$];
  bit          outstanding [2];
  int          age [2];
  bit          err_exp [2];
  logic [31:0] last_rdata [2];
  int          done_cnt [2];
  int          err_cnt [2];
  int          fram_ops = 0;
  int          fram_re_cnt = 0;

  bit          str_v [2];
  bit          str_we [2];
  logic [15:0] str_addr [2];
  logic [31:0] str_data [2];

  bit          c_active = 1'b0;
  bit          c_we;
  logic [15:0] c_addr;
  logic [31:0] c_data;
  int          c_cnt;
  int          force_lat = -1;
  bit          stray_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic done_of(input int p);
    return (p == 0) ? bus.m0_done : bus.m1_done;
  endfunction
  function automatic logic busy_of(input int p);
    return (p == 0) ? bus.m0_busy : bus.m1_busy;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? bus.m0_err : bus.m1_err;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? bus.m0_rdata : bus.m1_rdata;
  endfunction

  function automatic logic any_output();
    return |{bus.m0_rdata, bus.m0_done, bus.m0_busy, bus.m0_err,
             bus.m1_rdata, bus.m1_done, bus.m1_busy, bus.m1_err,
             bus.fram_address, bus.fram_write_data, bus.fram_we, bus.fram_re};
  endfunction

  // ---------------- driver ----------------
  task automatic set_port(input int p, input bit we, input bit re,
                          input logic [15:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.m0_we = we; bus.m0_re = re; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_we = we; bus.m1_re = re; bus.m1_addr = a; bus.m1_wdata = d;
    end
    str_v[p] = we | re; str_we[p] = we; str_addr[p] = a; str_data[p] = d;
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
    bus.m0_we = 1'b0; bus.m0_re = 1'b0;
    bus.m1_we = 1'b0; bus.m1_re = 1'b0;
    str_v[0] = 1'b0; str_v[1] = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cycle_end();
    cycle_end();
    rst_n = 1'b1;
    cycle_end();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((outstanding[0] || outstanding[1] || c_active) && n < 300) begin
      cycle_end();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
    cycle_end();
    cycle_end();
  endtask

  // ---------------- FRAM controller model ----------------
  initial begin
    logic [48:0] got;
    bus.fram_done = 1'b0;
    bus.fram_read_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c_active = 1'b0;
        bus.fram_done = 1'b0;
      end else begin
        bus.fram_done = 1'b0;
        if (c_active) begin
          check("fram_addr_stable", bus.fram_address, c_addr);
          check("fram_wdata_stable", bus.fram_write_data, c_data);
          if (c_cnt == 0) begin
            bus.fram_done = 1'b1;
            if (c_we) begin
              ctrl_mem[c_addr] = c_data;
              bus.fram_read_data = $urandom;
            end else begin
              bus.fram_read_data = ctrl_mem[c_addr];
            end
            c_active = 1'b0;
          end else begin
            c_cnt--;
          end
        end else if (bus.fram_we || bus.fram_re) begin
          check("fram_we_re_exclusive", bus.fram_we & bus.fram_re, 1'b0);
          fram_ops++;
          if (bus.fram_re) fram_re_cnt++;
          got = {bus.fram_we, bus.fram_address, bus.fram_write_data};
          checks++;
          if (req_q[0].size() > 0 && req_q[0][0] == got) begin
            void'(req_q[0].pop_front());
            fram_order.push_back(0);
          end else if (req_q[1].size() > 0 && req_q[1][0] == got) begin
            void'(req_q[1].pop_front());
            fram_order.push_back(1);
          end else begin
            errors++;
            $display("FAIL fram_request: got we/addr/data 0x%0h, required a queued request", got);
          end
          c_active = 1'b1;
          c_we = bus.fram_we;
          c_addr = bus.fram_address;
          c_data = bus.fram_write_data;
          c_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        end else if (stray_en && $urandom_range(0, 7) == 0) begin
          // Spurious completion while no transfer is outstanding.
          bus.fram_done = 1'b1;
          bus.fram_read_data = $urandom;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int p = 0; p < 2; p++) begin
          exp_q[p].delete();
          req_q[p].delete();
          outstanding[p] = 1'b0;
          age[p] = 0;
          err_exp[p] = 1'b0;
          last_rdata[p] = '0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          check($sformatf("m%0d_err", p), err_of(p), err_exp[p]);
          if (err_of(p)) err_cnt[p]++;
          if (done_of(p)) begin
            done_cnt[p]++;
            if (exp_q[p].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL m%0d_done: got unexpected done, required none", p);
            end else begin
              e = exp_q[p].pop_front();
              if (e[32]) begin
                check($sformatf("m%0d_rdata_read", p), rdata_of(p), e[31:0]);
                last_rdata[p] = e[31:0];
              end else begin
                check($sformatf("m%0d_rdata_write", p), rdata_of(p), last_rdata[p]);
              end
            end
            outstanding[p] = 1'b0;
            age[p] = 0;
          end
          check($sformatf("m%0d_busy", p), busy_of(p), outstanding[p]);
          if (outstanding[p]) begin
            age[p]++;
            if (age[p] > 200) begin
              checks++;
              errors++;
              $display("FAIL m%0d_timeout: no done after %0d cycles, required done", p, age[p]);
              outstanding[p] = 1'b0;
              exp_q[p].delete();
              req_q[p].delete();
            end
          end
          err_exp[p] = 1'b0;
          if (str_v[p]) begin
            if (outstanding[p]) begin
              err_exp[p] = 1'b1;
            end else begin
              outstanding[p] = 1'b1;
              age[p] = 0;
              if (str_we[p]) begin
                ref_mem[str_addr[p]] = str_data[p];
                exp_q[p].push_back({1'b0, 32'h0});
              end else begin
                exp_q[p].push_back({1'b1, ref_mem[str_addr[p]]});
              end
              req_q[p].push_back({str_we[p], str_addr[p], str_data[p]});
            end
          end
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int d0, d1, ops0, re0, e0;
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i]  = 32'(i) * 32'h9E37_79B1;
      ctrl_mem[i] = 32'(i) * 32'h9E37_79B1;
    end
    ref_mem[16'h0020]  = 32'h1234_5678;
    ctrl_mem[16'h0020] = 32'h1234_5678;
    for (int p = 0; p < 2; p++) begin
      done_cnt[p] = 0; err_cnt[p] = 0; str_v[p] = 1'b0;
      set_port(p, 1'b0, 1'b0, 16'h0, 32'h0);
    end

    // Reset values
    #12;
    check("reset_outputs_zero", any_output(), 1'b0);
    check("reset_state_idle", dbg_state, IDLE);
    cycle_end();
    rst_n = 1'b1;
    cycle_end();

    // Single write on m0, m1 untouched
    d1 = done_cnt[1]; ops0 = fram_ops;
    set_port(0, 1'b1, 1'b0, 16'h0010, 32'hDEAD_BEEF);
    cycle_end();
    wait_idle("m0_write");
    check("m0_write_fram_ops", fram_ops - ops0, 1);
    check("m0_write_mem", ctrl_mem[16'h0010], 32'hDEAD_BEEF);
    check("m0_write_m1_done", done_cnt[1] - d1, 0);

    // Single read on m1
    d1 = done_cnt[1];
    set_port(1, 1'b0, 1'b1, 16'h0020, 32'h0);
    cycle_end();
    wait_idle("m1_read");
    check("m1_read_done_count", done_cnt[1] - d1, 1);

    // Strobe while busy is dropped with err
    ops0 = fram_ops; e0 = err_cnt[0];
    set_port(0, 1'b0, 1'b1, 16'h0010, 32'h0);
    cycle_end();
    set_port(0, 1'b1, 1'b0, 16'h0011, 32'h5555_AAAA);
    cycle_end();
    wait_idle("m0_busy_drop");
    check("busy_drop_fram_ops", fram_ops - ops0, 1);
    check("busy_drop_err_count", err_cnt[0] - e0, 1);

    // we and re together behave as a write
    re0 = fram_re_cnt; ops0 = fram_ops;
    set_port(0, 1'b1, 1'b1, 16'h0012, 32'hCAFE_F00D);
    cycle_end();
    wait_idle("we_re_both");
    check("we_re_no_fram_re", fram_re_cnt - re0, 0);
    check("we_re_fram_ops", fram_ops - ops0, 1);
    check("we_re_mem", ctrl_mem[16'h0012], 32'hCAFE_F00D);

    // New strobe accepted in the RESP cycle
    ops0 = fram_ops; e0 = err_cnt[0];
    set_port(0, 1'b1, 1'b0, 16'h0013, 32'h0BAD_CAFE);
    cycle_end();
    for (int n = 0; n < 50 && !bus.m0_done; n++) cycle_end();
    set_port(0, 1'b0, 1'b1, 16'h0013, 32'h0);
    cycle_end();
    wait_idle("resp_chain");
    check("resp_chain_fram_ops", fram_ops - ops0, 2);
    check("resp_chain_err_count", err_cnt[0] - e0, 0);

    // Round robin after reset; an m0-only transfer then leaves m1 favoured
    reset_dut();
    fram_order.delete();
    set_port(0, 1'b1, 1'b0, 16'h0100, 32'hA0A0_0001);
    set_port(1, 1'b1, 1'b0, 16'h8100, 32'hB0B0_0001);
    cycle_end();
    wait_idle("rr_first");
    check("rr_first_count", fram_order.size(), 2);
    check("rr_first_winner", fram_order[0], 0);
    check("rr_first_second", fram_order[1], 1);
    set_port(0, 1'b0, 1'b1, 16'h0100, 32'h0);
    cycle_end();
    wait_idle("rr_single");
    set_port(0, 1'b0, 1'b1, 16'h0100, 32'h0);
    set_port(1, 1'b0, 1'b1, 16'h8100, 32'h0);
    cycle_end();
    wait_idle("rr_repeat");
    check("rr_repeat_count", fram_order.size(), 5);
    check("rr_repeat_winner", fram_order[3], 1);
    check("rr_repeat_second", fram_order[4], 0);

    // Reset during WAIT abandons the transfer
    force_lat = 20;
    d0 = done_cnt[0];
    set_port(0, 1'b0, 1'b1, 16'h0010, 32'h0);
    cycle_end();
    for (int n = 0; n < 20 && !c_active; n++) cycle_end();
    cycle_end();
    check("wait_reached", dbg_state, WAIT);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs_zero", any_output(), 1'b0);
    check("midreset_state_idle", dbg_state, IDLE);
    cycle_end();
    cycle_end();
    check("midreset_no_done", done_cnt[0] - d0, 0);
    rst_n = 1'b1;
    force_lat = -1;
    cycle_end();
    d0 = done_cnt[0];
    set_port(0, 1'b0, 1'b1, 16'h0010, 32'h0);
    cycle_end();
    wait_idle("after_reset");
    check("after_reset_done", done_cnt[0] - d0, 1);

    // Random traffic with spurious controller completions
    stray_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          int k;
          k = int'($urandom_range(0, 3));
          set_port(p, (k != 0), (k != 1),
                   {p[0], 11'h0, 4'($urandom_range(0, 15))}, $urandom);
        end
      end
      cycle_end();
    end
    stray_en = 1'b0;
    wait_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fram_arbiter.md
FRAM_ARBITER -- requirements
Module: fram_arbiter

Interface
REQ-001 Parameters: none; address width fixed at 16, data width fixed at 32.
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 m0_addr / m1_addr  input  16  requester FRAM byte address.
REQ-005 m0_wdata / m1_wdata  input  32  requester write data.
REQ-006 m0_we / m1_we  input  1  single-cycle write strobe.
REQ-007 m0_re / m1_re  input  1  single-cycle read strobe.
REQ-008 m0_rdata / m1_rdata  output  32  read result, valid with done.
REQ-009 m0_done / m1_done  output  1  one-cycle completion pulse.
REQ-010 m0_busy / m1_busy  output  1  port has a pending or active transaction.
REQ-011 m0_err / m1_err  output  1  one-cycle pulse: strobe rejected because port busy.
REQ-012 fram_address  output  16  to FRAM SPI controller address.
REQ-013 fram_write_data  output  32  to controller write_data.
REQ-014 fram_we / fram_re  output  1  to controller we/re, one-cycle pulses.
REQ-015 fram_read_data  input  32  from controller read_data.
REQ-016 fram_done  input  1  controller completion pulse.

Function
REQ-017 Strobe on an idle port SHALL latch addr, wdata and op into that port's holding register and set busy the next cycle.
REQ-018 we and re asserted together SHALL be latched as a write; re ignored, no err.
REQ-019 Strobe while port busy SHALL be dropped and SHALL pulse err for one cycle; holding register unchanged.
REQ-020 FSM states: IDLE, ISSUE, WAIT, RESP; illegal encodings SHALL return to IDLE.
REQ-021 IDLE: if any port pending, SHALL select grant and go ISSUE; else stay.
REQ-022 Selection SHALL be round-robin: single pending port wins; both pending -> port not granted last wins; after reset port 0 has priority.
REQ-023 ISSUE: fram_address/fram_write_data SHALL show granted port's latched values, fram_we or fram_re high exactly this one cycle; next state WAIT.
REQ-024 fram_address/fram_write_data SHALL hold stable from ISSUE until fram_done sampled.
REQ-025 WAIT: on fram_done high, SHALL capture fram_read_data (reads) and go RESP; no timeout.
REQ-026 RESP: granted port's done SHALL be high one cycle, rdata = captured data (reads) or unchanged (writes), busy cleared same cycle; next state IDLE.
REQ-027 A port SHALL accept a new strobe in its RESP cycle (busy clearing) as a new transaction.
REQ-028 fram_done outside WAIT SHALL be ignored.
REQ-029 Minimum latency strobe -> done SHALL be 3 cycles plus controller latency (capture, IDLE, ISSUE, WAIT..., RESP).

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, all outputs 0, holding registers and pending flags cleared, round-robin pointer to port 0.
REQ-031 Reset mid-transaction SHALL abandon it without done; the controller is reset by the same rst_n.

Structure
REQ-032 State encodings and port count constant SHALL reside in the shared FRAM package (fram_pkg).
REQ-033 One sub-module fram_port_latch (holding register, busy, err) SHALL be instantiated per port.

Verification
REQ-034 m0 write addr 0x0010 data 0xDEADBEEF -> one fram_we pulse with same values, m0_done once, m1 untouched.
REQ-035 m1 read addr 0x0020, controller model returns 0x12345678 -> m1_rdata 0x12345678 with m1_done.
REQ-036 m0 and m1 strobe same cycle after reset -> m0 served first, then m1; repeat -> m1 first.
REQ-037 m0 strobe again while busy -> m0_err one cycle, only one fram transaction issued.
REQ-038 m0_we and m0_re same cycle -> write issued, fram_re never high.
REQ-039 rst_n low during WAIT -> all outputs 0 immediately, no done; next request served normally.
